// File: rtl/hll_pkg.sv
// Shared constants, FSM state and command payload for the hyperloglog DMA read issuer.
package hll_pkg;
    localparam int unsigned DATA_BYTES = 64;
    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned BEAT_SHIFT = 6;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned LEN_W      = 32;
    localparam int unsigned DATA_W     = DATA_BYTES * 8;
    localparam int unsigned KEEP_W     = DATA_BYTES;
    localparam int unsigned PAGE_W     = 13;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } mem_cmd_t;

    function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                                 input logic [LEN_W-1:0] b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/hll_chunk_calc.sv
// Size of the next read command: bounded by bytes left, the chunk cap and the 4 KiB page end.
module hll_chunk_calc
    import hll_pkg::*;
#(
    parameter int unsigned MAX_CHUNK_BYTES = PAGE_BYTES
) (
    input  logic [PAGE_W-2:0] page_off_i,
    input  logic [LEN_W-1:0]  rem_i,
    output logic [PAGE_W-1:0] chunk_o
);
    logic [PAGE_W-1:0] page_left;
    logic [LEN_W-1:0]  cap;

    assign page_left = PAGE_W'(PAGE_BYTES) - {1'b0, page_off_i};
    assign cap       = min_len(LEN_W'(MAX_CHUNK_BYTES), LEN_W'(page_left));
    assign chunk_o   = PAGE_W'(min_len(rem_i, cap));
endmodule

// File: rtl/hll_dma_read_issuer.sv
// Splits one host buffer read into page-safe DMA commands and forwards the returned beats
// under a credit limit, tagging the final beat with last.
module hll_dma_read_issuer
    import hll_pkg::*;
#(
    parameter int unsigned MAX_CHUNK_BYTES    = 4096,
    parameter int unsigned MAX_INFLIGHT_BEATS = 512
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,

    output logic              m_axis_dma_read_cmd_valid,
    input  logic              m_axis_dma_read_cmd_ready,
    output logic [ADDR_W-1:0] m_axis_dma_read_cmd_address,
    output logic [LEN_W-1:0]  m_axis_dma_read_cmd_length,

    input  logic              s_axis_dma_read_data_tvalid,
    output logic              s_axis_dma_read_data_tready,
    input  logic [DATA_W-1:0] s_axis_dma_read_data_tdata,
    input  logic [KEEP_W-1:0] s_axis_dma_read_data_tkeep,
    input  logic              s_axis_dma_read_data_tlast,

    output logic              m_axis_read_data_tvalid,
    input  logic              m_axis_read_data_tready,
    output logic [DATA_W-1:0] m_axis_read_data_tdata,
    output logic [KEEP_W-1:0] m_axis_read_data_tkeep,
    output logic              m_axis_read_data_tlast,

    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  status_cycles,
    output logic [LEN_W-1:0]  status_beats
);
    state_e            state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  total_q, total_d;
    logic [LEN_W-1:0]  rcvd_q, rcvd_d;
    logic [LEN_W-1:0]  inflight_q, inflight_d;
    logic [LEN_W-1:0]  cycles_q, cycles_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [PAGE_W-1:0] chunk_bytes;
    logic [PAGE_W-1:0] chunk_beats;
    logic              start_edge;
    logic              credit_ok;
    logic              expecting;
    logic              cmd_hs;
    logic              beat_hs;
    logic              final_beat;
    mem_cmd_t          cmd;
    logic              unused_ok;

    hll_chunk_calc #(
        .MAX_CHUNK_BYTES (MAX_CHUNK_BYTES)
    ) u_chunk (
        .page_off_i (addr_q[PAGE_W-2:0]),
        .rem_i      (rem_q),
        .chunk_o    (chunk_bytes)
    );

    assign chunk_beats = chunk_bytes >> BEAT_SHIFT;
    assign start_edge  = start & ~start_q;
    assign credit_ok   = (inflight_q + LEN_W'(chunk_beats)) <= LEN_W'(MAX_INFLIGHT_BEATS);
    assign expecting   = busy_q & (rcvd_q < total_q);

    // Command channel is driven straight from registered state, so it holds while stalled.
    assign cmd = '{addr: addr_q, len: LEN_W'(chunk_bytes)};
    assign m_axis_dma_read_cmd_valid   = (state_q == ISSUE) & (rem_q != '0) & credit_ok;
    assign m_axis_dma_read_cmd_address = cmd.addr;
    assign m_axis_dma_read_cmd_length  = cmd.len;

    assign m_axis_read_data_tvalid     = s_axis_dma_read_data_tvalid & expecting;
    assign s_axis_dma_read_data_tready = m_axis_read_data_tready & expecting;
    assign m_axis_read_data_tdata      = s_axis_dma_read_data_tdata;
    assign m_axis_read_data_tkeep      = s_axis_dma_read_data_tkeep;
    assign m_axis_read_data_tlast      = (rcvd_q == total_q - 1'b1) & m_axis_read_data_tvalid;

    assign cmd_hs     = m_axis_dma_read_cmd_valid & m_axis_dma_read_cmd_ready;
    assign beat_hs    = s_axis_dma_read_data_tvalid & s_axis_dma_read_data_tready;
    assign final_beat = beat_hs & (rcvd_q == total_q - 1'b1);

    assign busy          = busy_q;
    assign done          = done_q;
    assign status_cycles = cycles_q;
    assign status_beats  = rcvd_q;

    // Upstream tlast is ignored; the beat count alone defines the end of a job.
    assign unused_ok = ^{s_axis_dma_read_data_tlast, base_addr[BEAT_SHIFT-1:0],
                         length[BEAT_SHIFT-1:0]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        total_d    = total_q;
        rcvd_d     = rcvd_q;
        inflight_d = inflight_q;
        cycles_d   = cycles_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (busy_q) cycles_d = cycles_q + 1'b1;
        if (beat_hs) rcvd_d = rcvd_q + 1'b1;
        // Command credit and returned beat may coincide; fold both into one update.
        inflight_d = inflight_q + (cmd_hs ? LEN_W'(chunk_beats) : '0) - LEN_W'(beat_hs);
        if (cmd_hs) begin
            addr_d = addr_q + ADDR_W'(chunk_bytes);
            rem_d  = rem_q - LEN_W'(chunk_bytes);
        end

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    addr_d     = {base_addr[ADDR_W-1:BEAT_SHIFT], BEAT_SHIFT'(0)};
                    rem_d      = {length[LEN_W-1:BEAT_SHIFT], BEAT_SHIFT'(0)};
                    total_d    = LEN_W'(length[LEN_W-1:BEAT_SHIFT]);
                    rcvd_d     = '0;
                    cycles_d   = '0;
                    inflight_d = '0;
                    if (length[LEN_W-1:BEAT_SHIFT] == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        busy_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (final_beat) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end else if (cmd_hs && (rem_q == LEN_W'(chunk_bytes))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (final_beat) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            total_q    <= '0;
            rcvd_q     <= '0;
            inflight_q <= '0;
            cycles_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            total_q    <= total_d;
            rcvd_q     <= rcvd_d;
            inflight_q <= inflight_d;
            cycles_q   <= cycles_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule
